vga_text_renderer: RTL

- Upstream pixel-source stage for the VGA sync block.
- Turns the sync block's raster counters into a 1-bit "text pixel on" signal from an 80x30 character buffer and an 8x16 font ROM.
- The sync block uses this pixel to choose the foreground or background colour.
- A write port lets the rest of the design (CPU/memory side) update displayed characters at any time.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/font_rom_8x16.sv | 38 +++
 rtl/vga_text_renderer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing, geometry and type definitions for the VGA text renderer.
package vga_pkg;

  localparam int H_TOTAL  = 800;
  localparam int V_LAST   = 525;
  localparam int ACTIVE_W = 640;
  localparam int ACTIVE_H = 480;
  localparam int H_START  = 145;
  localparam int V_START  = 36;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CELLS  = 2400;

  localparam int BLINK_FRAMES = 32;

  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] PINK  = 24'hF245C0;

  typedef logic [11:0] cell_addr_t;
  typedef logic [7:0]  char_t;

endpackage

// File: rtl/font_rom_8x16.sv
// 4096x8 synchronous glyph ROM addressed by {char, fy}; one registered read port.
// The glyph table lives only here so the character set can be replaced wholesale.
module font_rom_8x16 (
  input  logic        clk,
  input  logic [11:0] addr,
  output logic [7:0]  data
);

  logic [7:0] w_data;
  logic [7:0] r_data;

  // Blank glyphs are the default; only 'A' (0x41) and the full block (0xDB) are drawn.
  always_comb begin
    w_data = 8'h00;
    case (addr)
      12'h412: w_data = 8'h10;
      12'h413: w_data = 8'h38;
      12'h414: w_data = 8'h6C;
      12'h415: w_data = 8'hC6;
      12'h416: w_data = 8'hC6;
      12'h417: w_data = 8'hFE;
      12'h418: w_data = 8'hC6;
      12'h419: w_data = 8'hC6;
      12'h41A: w_data = 8'hC6;
      12'h41B: w_data = 8'hC6;
      default: begin
        if (addr[11:4] == 8'hDB) w_data = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    r_data <= w_data;
  end

  assign data = r_data;

endmodule

// File: rtl/vga_text_renderer.sv
// Raster-counter to text-pixel pipeline (latency 3) over an 80x30 char buffer and 8x16 font.
// Optional blinking block cursor is compiled in with `define CURSOR_BLINK_EN.
module vga_text_renderer #(
  parameter int H_START      = vga_pkg::H_START,
  parameter int V_START      = vga_pkg::V_START,
  parameter int COLS         = vga_pkg::COLS,
  parameter int ROWS         = vga_pkg::ROWS,
  parameter int BLINK_FRAMES = vga_pkg::BLINK_FRAMES
) (
  input  logic        VGA_CLK_IN,
  input  logic        reset,
  input  logic [9:0]  counter_x,
  input  logic [9:0]  counter_y,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [11:0] cursor_addr,
  output logic        pixel,
  output logic        pixel_valid
);

  import vga_pkg::*;

  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic        w_active;
  logic [6:0]  w_col;
  logic [5:0]  w_row;
  cell_addr_t  w_addr;
  logic [7:0]  w_row_bits;
  logic [7:0]  w_bits;

  cell_addr_t  r_addr1;
  logic [2:0]  r_fx1;
  logic [3:0]  r_fy1;
  logic        r_act1;
  char_t       r_code2;
  logic [2:0]  r_fx2;
  logic [3:0]  r_fy2;
  logic        r_act2;
  logic [2:0]  r_fx3;
  logic        r_act3;

  char_t r_mem [0:CELLS-1] = '{default: 8'h20};

  assign w_dx = counter_x - 10'(H_START);
  assign w_dy = counter_y - 10'(V_START);
  assign w_active = (counter_x >= 10'(H_START)) && (counter_x < 10'(H_START + ACTIVE_W)) &&
                    (counter_y >= 10'(V_START)) && (counter_y < 10'(V_START + ACTIVE_H));
  assign w_col = w_dx[9:3];
  assign w_row = w_dy[9:4];
  // row*80 as row*64 + row*16 keeps the address path adder-only.
  assign w_addr = {w_row, 6'b0} + {2'b0, w_row, 4'b0} + {5'b0, w_col};

  always_ff @(posedge VGA_CLK_IN) begin
    if (wr_en && (wr_addr < 12'(CELLS))) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge VGA_CLK_IN) begin
    if (reset) begin
      r_addr1 <= '0;
      r_fx1   <= '0;
      r_fy1   <= '0;
      r_act1  <= 1'b0;
      r_code2 <= '0;
      r_fx2   <= '0;
      r_fy2   <= '0;
      r_act2  <= 1'b0;
      r_fx3   <= '0;
      r_act3  <= 1'b0;
    end else begin
      r_addr1 <= w_addr;
      r_fx1   <= w_dx[2:0];
      r_fy1   <= w_dy[3:0];
      r_act1  <= w_active;
      // Out-of-range addresses only occur outside the active area; read a blank there.
      r_code2 <= (r_addr1 < 12'(CELLS)) ? r_mem[r_addr1] : 8'h20;
      r_fx2   <= r_fx1;
      r_fy2   <= r_fy1;
      r_act2  <= r_act1;
      r_fx3   <= r_fx2;
      r_act3  <= r_act2;
    end
  end

  font_rom_8x16 u_font (
    .clk  (VGA_CLK_IN),
    .addr ({r_code2, r_fy2}),
    .data (w_row_bits)
  );

`ifdef CURSOR_BLINK_EN
  logic [15:0] r_frame_cnt;
  logic        r_blink;
  logic        r_cur2;
  logic        r_cur3;

  always_ff @(posedge VGA_CLK_IN) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
      r_cur2      <= 1'b0;
      r_cur3      <= 1'b0;
    end else begin
      if ((counter_x == 10'(H_TOTAL - 1)) && (counter_y == 10'(V_LAST))) begin
        if (r_frame_cnt == 16'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_blink     <= ~r_blink;
        end else begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end
      r_cur2 <= r_blink && (cursor_addr < 12'(CELLS)) && (r_addr1 == cursor_addr);
      r_cur3 <= r_cur2;
    end
  end

  assign w_bits = w_row_bits ^ {8{r_cur3}};
`else
  logic w_unused_cursor;
  assign w_unused_cursor = ^{cursor_addr, 1'b0};
  assign w_bits = w_row_bits;
`endif

  assign pixel       = r_act3 & w_bits[3'd7 - r_fx3];
  assign pixel_valid = r_act3;

endmodule
